// File: rtl/cv32e40x_instr_obi_responder.sv
// -----------------------------------------------------------------------------
// cv32e40x_instr_obi_responder
//
// OBI instruction-side responder. It accepts A-channel requests from an
// instruction fetch master and reads the addressed word from a synchronous
// SRAM (one cycle read latency). It returns the word on the R channel exactly
// RESP_LATENCY cycles after the grant, strictly in request order. Addresses
// beyond the SRAM are answered with err=1 and rdata=0, and they never touch
// the SRAM.
//
// Parameters
//   RESP_LATENCY     grant-to-rvalid latency in cycles (1..8)
//   MAX_OUTSTANDING  granted-but-unanswered transaction limit (1..8)
//   MEM_ADDR_WIDTH   SRAM word-address width
//
// Optional feature (compile-time macro)
//   CV32E40X_OBI_RESP_GNT_STALL_EN  holds off each new request for 3 cycles
//                                   before it can be granted
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   obi_req_i      A-channel request        obi_gnt_o    A-channel grant
//   obi_addr_i     byte address ([1:0] ignored)
//   obi_rvalid_o   R-channel valid (master always ready)
//   obi_rdata_o    instruction word         obi_err_o    out-of-range error
//   mem_req_o      SRAM read enable         mem_addr_o   SRAM word address
//   mem_rdata_i    SRAM read data, valid one cycle after mem_req_o
// -----------------------------------------------------------------------------
module cv32e40x_instr_obi_responder #(
  parameter int unsigned RESP_LATENCY    = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MEM_ADDR_WIDTH  = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      obi_req_i,
  output logic                      obi_gnt_o,
  input  logic [31:0]               obi_addr_i,
  output logic                      obi_rvalid_o,
  output logic [31:0]               obi_rdata_o,
  output logic                      obi_err_o,
  output logic                      mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // One slot of the response pipeline; data travels in a separate chain.
  typedef struct packed {
    logic valid;
    logic err;
    logic from_mem;
  } stage_t;

  stage_t           pipe_q [RESP_LATENCY];
  logic [CNT_W-1:0] outstanding_q;
  logic             in_range;
  logic             stall;
  logic             handshake;
  logic             retire;
  logic [31:0]      resp_data;
  logic             addr_lsb_unused;

  // Byte-offset bits carry no meaning for word fetches.
  assign addr_lsb_unused = ^obi_addr_i[1:0];

  assign in_range   = (obi_addr_i[31:MEM_ADDR_WIDTH+2] == '0);
  assign mem_addr_o = obi_addr_i[MEM_ADDR_WIDTH+1:2];

  // A response leaving the pipeline this cycle frees its slot, so a full
  // responder may still grant in the same cycle.
  assign retire    = pipe_q[RESP_LATENCY-1].valid;
  assign obi_gnt_o = obi_req_i & ((outstanding_q < MAX_CNT) | retire) & ~stall;
  assign handshake = obi_req_i & obi_gnt_o;
  assign mem_req_o = handshake & in_range;

`ifdef CV32E40X_OBI_RESP_GNT_STALL_EN
  logic [1:0] stall_cnt_q;
  logic [1:0] stall_cnt_eff;
  logic       req_q;
  logic       gnt_q;
  logic       stall_load;

  // A new request is one that just rose, or one still asserted after the
  // previous grant. The load cycle itself counts as the first stall cycle,
  // so the earliest grant comes 3 cycles after the request appears.
  assign stall_load    = obi_req_i & (~req_q | gnt_q);
  assign stall_cnt_eff = stall_load ? 2'd3 : stall_cnt_q;
  assign stall         = (stall_cnt_eff != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 2'd0;
      req_q       <= 1'b0;
      gnt_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall ? (stall_cnt_eff - 2'd1) : 2'd0;
      req_q       <= obi_req_i;
      gnt_q       <= obi_gnt_o;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RESP_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: handshake, err: handshake & ~in_range, from_mem: mem_req_o};
      for (int i = 1; i < int'(RESP_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      unique case ({handshake, retire})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // SRAM data arrives one cycle after the grant, i.e. while the transaction
  // sits in pipe_q[0]; it then follows the control pipeline in lock step.
  if (RESP_LATENCY == 1) begin : g_direct
    assign resp_data = mem_rdata_i;
  end else begin : g_chain
    logic [31:0] data_q [RESP_LATENCY-1];

    // NOTE: the data chain has no reset; obi_rdata_o is masked by the reset
    // control pipeline, so stale data is never visible.
    always_ff @(posedge clk) begin
      if (pipe_q[0].from_mem) data_q[0] <= mem_rdata_i;
      for (int i = 1; i < int'(RESP_LATENCY) - 1; i++) data_q[i] <= data_q[i-1];
    end

    assign resp_data = data_q[RESP_LATENCY-2];
  end

  assign obi_rvalid_o = pipe_q[RESP_LATENCY-1].valid;
  assign obi_err_o    = pipe_q[RESP_LATENCY-1].err;
  assign obi_rdata_o  = pipe_q[RESP_LATENCY-1].from_mem ? resp_data : 32'h0;

  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, outstanding_q} <= {1'b0, MAX_CNT});
  a_cnt_min: assert property (@(posedge clk) disable iff (!rst_n)
    !(retire && !handshake && (outstanding_q == '0)));

endmodule

// File: tb/tb_cv32e40x_instr_obi_responder.sv
module tb_cv32e40x_instr_obi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic        mreq   [2];
  logic [11:0] maddr  [2];
  logic [31:0] mrdata [2];
  logic [31:0] mem    [4096];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance 0: default configuration. Instance 1: single outstanding, latency 4.
  cv32e40x_instr_obi_responder u_dut0 (
    .clk(clk), .rst_n(rst_n), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]),
    .obi_addr_i(addr[0]), .obi_rvalid_o(rvalid[0]), .obi_rdata_o(rdata[0]),
    .obi_err_o(err[0]), .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]),
    .mem_rdata_i(mrdata[0])
  );

  cv32e40x_instr_obi_responder #(.RESP_LATENCY(4), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]),
    .obi_addr_i(addr[1]), .obi_rvalid_o(rvalid[1]), .obi_rdata_o(rdata[1]),
    .obi_err_o(err[1]), .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]),
    .mem_rdata_i(mrdata[1])
  );

  // Synchronous SRAM models, one read cycle.
  always @(posedge clk) if (mreq[0]) mrdata[0] <= mem[maddr[0]];
  always @(posedge clk) if (mreq[1]) mrdata[1] <= mem[maddr[1]];

  function automatic logic [31:0] memw(input int i);
    return (i == 4) ? 32'h0000_0013 : (32'hA500_0000 | 32'(i));
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int maxo(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req[0] = 1'b0; req[1] = 1'b0;
    addr[0] = '0;  addr[1] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a calendar of responses indexed by the cycle they are due.
  // ---------------------------------------------------------------------------
  bit          sv [2][16];
  logic [31:0] sd [2][16];
  bit          se [2][16];
  int          oc [2];
  int          age [2];
  bit          prev_req [2];
  bit          prev_gnt [2];
  int          cyc;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 16; s++) begin sv[d][s] = 0; sd[d][s] = '0; se[d][s] = 0; end
      oc[d] = 0; age[d] = 0; prev_req[d] = 0; prev_gnt[d] = 0;
    end
    cyc = 0;
  endtask

  task automatic step(input int d);
    int   slot;
    bit   due;
    bit   stall;
    bit   g;
    bit   ok;
    slot  = cyc % 16;
    due   = sv[d][slot];
    stall = 0;
`ifdef CV32E40X_OBI_RESP_GNT_STALL_EN
    // A request is new when it appears or persists past a grant; it becomes
    // grantable once it has been waiting 3 cycles.
    if (req[d] && (!prev_req[d] || prev_gnt[d])) age[d] = 0;
    else if (age[d] < 3) age[d]++;
    stall = req[d] && (age[d] < 3);
`endif
    ok = addr[d] < 32'h4000;
    g  = req[d] && ((oc[d] < maxo(d)) || due) && !stall;
    check($sformatf("rnd d%0d c%0d gnt", d, cyc), gnt[d], g);
    check($sformatf("rnd d%0d c%0d mem_req", d, cyc), mreq[d], g && ok);
    check($sformatf("rnd d%0d c%0d rvalid", d, cyc), rvalid[d], due);
    check($sformatf("rnd d%0d c%0d rdata", d, cyc), rdata[d], due ? sd[d][slot] : 32'h0);
    check($sformatf("rnd d%0d c%0d err", d, cyc), err[d], due ? se[d][slot] : 1'b0);
    if (due) begin sv[d][slot] = 0; oc[d]--; end
    if (g) begin
      slot = (cyc + lat(d)) % 16;
      sv[d][slot] = 1;
      sd[d][slot] = ok ? mem[addr[d][13:2]] : 32'h0;
      se[d][slot] = !ok;
      oc[d]++;
    end
    prev_req[d] = req[d];
    prev_gnt[d] = g;
  endtask

  // ---------------------------------------------------------------------------
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        mreq;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic g,
                              input logic v, input logic [31:0] d, input logic e,
                              input logic m);
    vec_t t;
    t.req = r; t.addr = a; t.gnt = g; t.rvalid = v; t.rdata = d; t.err = e; t.mreq = m;
    return t;
  endfunction

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = memw(i);
    req[0] = 1'b0; req[1] = 1'b0; addr[0] = '0; addr[1] = '0;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d gnt", d), gnt[d], 1'b0);
      check($sformatf("reset d%0d rvalid", d), rvalid[d], 1'b0);
      check($sformatf("reset d%0d rdata", d), rdata[d], 32'h0);
      check($sformatf("reset d%0d err", d), err[d], 1'b0);
      check($sformatf("reset d%0d mem_req", d), mreq[d], 1'b0);
    end
    do_reset();

`ifndef CV32E40X_OBI_RESP_GNT_STALL_EN
    // Single fetch, out-of-range fetch, 6-deep back-to-back burst (instance 0)
    tbl[0]  = mk(1, 32'h10,   1, 0, 32'h0,  0, 1);
    tbl[1]  = mk(0, 32'h0,    0, 0, 32'h0,  0, 0);
    tbl[2]  = mk(0, 32'h0,    0, 1, 32'h13, 0, 0);
    tbl[3]  = mk(1, 32'h4000, 1, 0, 32'h0,  0, 0);
    tbl[4]  = mk(0, 32'h0,    0, 0, 32'h0,  0, 0);
    tbl[5]  = mk(0, 32'h0,    0, 1, 32'h0,  1, 0);
    tbl[6]  = mk(1, 32'h0,    1, 0, 32'h0,  0, 1);
    tbl[7]  = mk(1, 32'h4,    1, 0, 32'h0,  0, 1);
    tbl[8]  = mk(1, 32'h8,    1, 1, memw(0), 0, 1);
    tbl[9]  = mk(1, 32'hC,    1, 1, memw(1), 0, 1);
    tbl[10] = mk(1, 32'h10,   1, 1, memw(2), 0, 1);
    tbl[11] = mk(1, 32'h14,   1, 1, memw(3), 0, 1);
    tbl[12] = mk(0, 32'h0,    0, 1, 32'h13,  0, 0);
    tbl[13] = mk(0, 32'h0,    0, 1, memw(5), 0, 0);
    tbl[14] = mk(0, 32'h0,    0, 0, 32'h0,   0, 0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      req[0] = tbl[i].req; addr[0] = tbl[i].addr;
      @(negedge clk);
      check($sformatf("tbl%0d gnt", i), gnt[0], tbl[i].gnt);
      check($sformatf("tbl%0d rvalid", i), rvalid[0], tbl[i].rvalid);
      check($sformatf("tbl%0d rdata", i), rdata[0], tbl[i].rdata);
      check($sformatf("tbl%0d err", i), err[0], tbl[i].err);
      check($sformatf("tbl%0d mem_req", i), mreq[0], tbl[i].mreq);
    end

    // Instance 1: req held high, one grant per 4 cycles, grants on rvalid cycles
    begin
      int k = 0;
      for (int j = 0; j < 13; j++) begin
        @(posedge clk); #1;
        req[1] = 1'b1; addr[1] = 32'(4 * (20 + k));
        @(negedge clk);
        check($sformatf("max1 c%0d gnt", j), gnt[1], (j % 4) == 0);
        check($sformatf("max1 c%0d rvalid", j), rvalid[1], (j >= 4) && ((j % 4) == 0));
        if ((j >= 4) && ((j % 4) == 0))
          check($sformatf("max1 c%0d rdata", j), rdata[1], memw(20 + j / 4 - 1));
        if ((j % 4) == 0) k++;
      end
      @(posedge clk); #1; req[1] = 1'b0;
    end

    // Reset mid-flight
    do_reset();
    @(posedge clk); #1;
    req[0] = 1'b1; addr[0] = 32'h10; req[1] = 1'b1; addr[1] = 32'h10;
    @(negedge clk);
    check("rst_mid grant0 d0", gnt[0], 1'b1);
    check("rst_mid grant0 d1", gnt[1], 1'b1);
    @(posedge clk); #1;
    addr[0] = 32'h14; req[1] = 1'b0;
    @(negedge clk);
    check("rst_mid grant1 d0", gnt[0], 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    check("rst_mid during d0 rvalid", rvalid[0], 1'b0);
    check("rst_mid during d1 rvalid", rvalid[1], 1'b0);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("rst_mid after c%0d d0 rvalid", j), rvalid[0], 1'b0);
      check($sformatf("rst_mid after c%0d d1 rvalid", j), rvalid[1], 1'b0);
    end
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      req[0] = (j == 0); req[1] = (j == 0); addr[0] = 32'h10; addr[1] = 32'h10;
      @(negedge clk);
      if (j == 0) begin
        check("rst_mid refetch d0 gnt", gnt[0], 1'b1);
        check("rst_mid refetch d1 gnt", gnt[1], 1'b1);
      end
      check($sformatf("rst_mid refetch c%0d d0 rvalid", j), rvalid[0], j == 2);
      check($sformatf("rst_mid refetch c%0d d1 rvalid", j), rvalid[1], j == 4);
      check($sformatf("rst_mid refetch c%0d d0 rdata", j), rdata[0], (j == 2) ? 32'h13 : 32'h0);
      check($sformatf("rst_mid refetch c%0d d1 rdata", j), rdata[1], (j == 4) ? 32'h13 : 32'h0);
    end
`else
    // Grant stall: request rises at cycle 0, granted at cycle 3, answered at 5
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      req[0] = (j <= 3); addr[0] = 32'h10;
      @(negedge clk);
      check($sformatf("stall c%0d gnt", j), gnt[0], j == 3);
      check($sformatf("stall c%0d rvalid", j), rvalid[0], j == 5);
      check($sformatf("stall c%0d rdata", j), rdata[0], (j == 5) ? 32'h13 : 32'h0);
    end
`endif

    // Randomized traffic on both instances against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (!(prev_req[d] && !prev_gnt[d])) begin
          int r = int'($urandom_range(0, 9));
          req[d] = ($urandom_range(0, 3) != 0);
          if (r < 7)      addr[d] = (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(0, 3));
          else if (r < 9) addr[d] = 32'h0000_4000 | $urandom;
          else            addr[d] = ($urandom_range(0, 1) != 0) ? 32'h3FFC : 32'h4000;
        end
      end
      @(negedge clk);
      step(0);
      step(1);
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
